// File: rtl/score_display_driver.sv
// ----------------------------------------------------------------------------
// score_display_driver
//
// Takes the BCD run-time score from the slow 1 Hz domain and resynchronises it
// into clk. Keeps a best-score register that updates at game over, and drives a
// 4-digit multiplexed, active-low 7-segment display. The display shows either
// the live score or the best score. The display blinks after a new record
// until game over clears.
//
// Optional feature macro: SCORE_LZB_EN
//   defined   -> leading-zero blanking (0000 shows "0")
//   undefined -> all four digits are always shown (0000 shows "0000")
//
// Ports
//   clk        : system clock, single domain for all state
//   reset_n    : asynchronous active-low reset
//   score      : four BCD digits, [15:12] most significant, from the 1 Hz domain
//   gameover   : level, asynchronous, high while the game is over
//   show_best  : 1 shows best, 0 shows the live score snapshot
//   clear_best : one-clk pulse, zeroes best and new_record
//   an         : digit enables, active low, an[0] = least significant digit
//   seg        : {dp,g,f,e,d,c,b,a}, active low
//   best       : best score (BCD)
//   new_record : set when the last game over beat best
// ----------------------------------------------------------------------------
module score_display_driver #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 125
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] score,
    input  logic        gameover,
    input  logic        show_best,
    input  logic        clear_best,
    output logic [3:0]  an,
    output logic [7:0]  seg,
    output logic [15:0] best,
    output logic        new_record
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = $clog2(BLINK_DIV + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_DIV - 1);

    // Active-low segment pattern for one nibble; A-F show a dash.
    function automatic logic [7:0] f_seg7(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0:    s = 8'hC0;
            4'h1:    s = 8'hF9;
            4'h2:    s = 8'hA4;
            4'h3:    s = 8'hB0;
            4'h4:    s = 8'h99;
            4'h5:    s = 8'h92;
            4'h6:    s = 8'h82;
            4'h7:    s = 8'hF8;
            4'h8:    s = 8'h80;
            4'h9:    s = 8'h90;
            default: s = 8'hBF;
        endcase
        return s;
    endfunction

    logic [15:0]   r_s1, r_s2, r_snap, r_best;
    logic          r_g1, r_g2, r_g3, r_new_record;
    logic [PW-1:0] r_presc;
    logic [1:0]    r_digit;
    logic [FW-1:0] r_frame;
    logic          r_blink;
    logic [3:0]    r_an;
    logic [7:0]    r_seg;

    logic          w_rise, w_tc, w_lz, w_blank, w_dp_on;
    logic [15:0]   w_src;
    logic [3:0]    w_nib, w_an_dig, w_an_nxt;
    logic [7:0]    w_seg_raw, w_seg_nxt;

    assign w_rise     = r_g2 & ~r_g3;
    assign w_tc       = (r_presc == PRESC_LAST);
    assign an         = r_an;
    assign seg        = r_seg;
    assign best       = r_best;
    assign new_record = r_new_record;

    // Score and gameover synchronisers; snap only loads when two samples agree,
    // so a torn multi-bit transition is never captured.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1   <= 16'h0000;
            r_s2   <= 16'h0000;
            r_snap <= 16'h0000;
            r_g1   <= 1'b0;
            r_g2   <= 1'b0;
            r_g3   <= 1'b0;
        end else begin
            r_s1 <= score;
            r_s2 <= r_s1;
            if (r_s1 == r_s2) begin
                r_snap <= r_s2;
            end
            r_g1 <= gameover;
            r_g2 <= r_g1;
            r_g3 <= r_g2;
        end
    end

    // Best-score tracking. clear_best beats a simultaneous game-over event.
    // new_record drops on the same edge that takes g2 low (g1 already low).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_best       <= 16'h0000;
            r_new_record <= 1'b0;
        end else if (clear_best) begin
            r_best       <= 16'h0000;
            r_new_record <= 1'b0;
        end else if (w_rise) begin
            if (r_snap > r_best) begin
                r_best       <= r_snap;
                r_new_record <= 1'b1;
            end
        end else if (!r_g1) begin
            r_new_record <= 1'b0;
        end
    end

    // Scan timing: prescaler -> digit slot -> frame count -> blink phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= '0;
            r_digit <= 2'd0;
            r_frame <= '0;
            r_blink <= 1'b0;
        end else if (w_tc) begin
            r_presc <= '0;
            r_digit <= r_digit + 2'd1;
            if (r_digit == 2'd3) begin
                if (r_frame == FRAME_LAST) begin
                    r_frame <= '0;
                    r_blink <= ~r_blink;
                end else begin
                    r_frame <= r_frame + FW'(1);
                end
            end
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // Next slot contents for the current digit: source select, nibble pick,
    // decode, dp, leading-zero and blink blanking.
    always_comb begin
        w_src    = show_best ? r_best : r_snap;
        w_nib    = 4'h0;
        w_an_dig = 4'hF;
        w_lz     = 1'b0;
        case (r_digit)
            2'd0: begin
                w_nib    = w_src[3:0];
                w_an_dig = 4'b1110;
            end
            2'd1: begin
                w_nib    = w_src[7:4];
                w_an_dig = 4'b1101;
`ifdef SCORE_LZB_EN
                w_lz     = (w_src[15:4] == 12'h000);
`endif
            end
            2'd2: begin
                w_nib    = w_src[11:8];
                w_an_dig = 4'b1011;
`ifdef SCORE_LZB_EN
                w_lz     = (w_src[15:8] == 8'h00);
`endif
            end
            2'd3: begin
                w_nib    = w_src[15:12];
                w_an_dig = 4'b0111;
`ifdef SCORE_LZB_EN
                w_lz     = (w_src[15:12] == 4'h0);
`endif
            end
            default: begin
                w_nib    = 4'h0;
                w_an_dig = 4'hF;
                w_lz     = 1'b0;
            end
        endcase
        w_dp_on   = show_best & (r_digit == 2'd0);
        w_seg_raw = f_seg7(w_nib);
        w_blank   = w_lz | (r_new_record & r_blink);
        if (w_blank) begin
            w_an_nxt  = 4'hF;
            w_seg_nxt = 8'hFF;
        end else begin
            w_an_nxt  = w_an_dig;
            w_seg_nxt = {w_seg_raw[7] & ~w_dp_on, w_seg_raw[6:0]};
        end
    end

    // Display registers load the slot for the current digit at terminal count,
    // so a mid-slot source change only shows at the next boundary.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_an  <= 4'hF;
            r_seg <= 8'hFF;
        end else if (w_tc) begin
            r_an  <= w_an_nxt;
            r_seg <= w_seg_nxt;
        end
    end

endmodule
